// File: rtl/seqdet_pkg.sv
// Shared types and default parameter values for the serial pattern detector.
package seqdet_pkg;

  // Moore states: FILL while history is short, HUNT when full with no match,
  // DETECT for the single cycle after a match completes.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HUNT   = 2'd1,
    DETECT = 2'd2
  } state_t;

  localparam int          PAT_W_DEF   = 4;
  localparam int          CNT_W_DEF   = 8;
  // Wide enough for the largest legal pattern. The top slices the low PAT_W bits.
  localparam logic [15:0] RST_PAT_DEF = 16'h000B;

endpackage

// File: rtl/seqdet_shift.sv
// Serial history register and saturating fill counter.
// The *_upd outputs are the post-shift values, so the top can compare against
// the pattern on the same edge that shifts the bit in.
module seqdet_shift #(
  parameter int PAT_W = 4,
  parameter int FW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             x,
  input  logic             fill_clr,
  output logic [FW-1:0]    fill,
  output logic [PAT_W-1:0] hist_upd,
  output logic [FW-1:0]    fill_upd
);

  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [PAT_W-1:0] hist;

  // Next history and fill values, assuming a bit is accepted this cycle.
  always_comb begin
    hist_upd = {hist[PAT_W-2:0], x};
    fill_upd = (fill == FULL) ? fill : fill + FW'(1);
  end

  // Shift on accepted bits. A clear takes priority over the fill increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift_en) hist <= hist_upd;
      if (fill_clr)      fill <= '0;
      else if (shift_en) fill <= fill_upd;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterized serial sequence detector with a Moore detect flag.
// Optional match counter: define SEQDET_COUNT_EN to build it. When the macro
// is not defined, match_cnt is tied to zero.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] RST_PAT = RST_PAT_DEF[PAT_W-1:0],
  parameter int               CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_reg;
  logic [PAT_W-1:0] hist_upd;
  logic [FW-1:0]    fill, fill_upd;
  logic             shift_en, detect, fill_clr;

  // A load wins over data, so a bit presented with pat_load is dropped.
  // In non-overlapping mode, history is discarded on the detecting edge.
  assign shift_en = x_valid & ~pat_load;
  assign detect   = shift_en && (fill_upd == FULL) && (hist_upd == pat_reg);
  assign fill_clr = pat_load | (detect & ~overlap);

  seqdet_shift #(.PAT_W(PAT_W), .FW(FW)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (shift_en),
    .x        (x),
    .fill_clr (fill_clr),
    .fill     (fill),
    .hist_upd (hist_upd),
    .fill_upd (fill_upd)
  );

  // Pattern register: armed with RST_PAT and replaced on load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pat_reg <= RST_PAT;
    else if (pat_load) pat_reg <= pattern;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next state. On an idle cycle, DETECT exits according to fill, which was
  // already cleared or kept by the overlap value sampled on the detecting edge.
  always_comb begin
    state_nxt = state;
    if (pat_load)
      state_nxt = FILL;
    else if (shift_en)
      state_nxt = detect ? DETECT : ((fill_upd == FULL) ? HUNT : FILL);
    else if (state == DETECT)
      state_nxt = (fill == FULL) ? HUNT : FILL;
  end

  assign z = (state == DETECT);

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  // Count edges that enter DETECT. The count saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (pat_load)           cnt <= '0;
    else if (detect && cnt != '1) cnt <= cnt + CNT_W'(1);
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=4, CNT_W=2).
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x = 1'b0, x_valid = 1'b0, pat_load = 1'b0, overlap = 1'b0;
  logic [3:0] pattern = '0;
  logic       z;
  logic [1:0] match_cnt;

  typedef struct {
    string      tag;
    logic       z;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0, fails = 0;
  logic [1:0] cnt_m = '0;

  seq_detector_param #(.PAT_W(4), .RST_PAT(4'b1011), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .x_valid   (x_valid),
    .pattern   (pattern),
    .pat_load  (pat_load),
    .overlap   (overlap),
    .z         (z),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_cnt();
`ifdef SEQDET_COUNT_EN
    return cnt_m;
`else
    return 2'd0;
`endif
  endfunction

  // Drive one cycle, push the expected outputs, then pop and compare after the edge.
  task automatic drive(input logic v, input logic b, input logic pl, input logic ez, input string tag);
    exp_t e;
    @(negedge clk);
    x_valid = v; x = b; pat_load = pl;
    if (pl) cnt_m = '0;
    else if (ez && cnt_m != 2'b11) cnt_m = cnt_m + 2'd1;
    sb.push_back('{tag, ez, exp_cnt()});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s: scoreboard empty got 0 want 1", tag);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".z"}, {3'b0, z}, {3'b0, e.z});
      chk({e.tag, ".cnt"}, {2'b0, match_cnt}, {2'b0, e.cnt});
    end
  endtask

  task automatic load(input logic [3:0] p, input logic ov, input logic v, input logic b, input string tag);
    pattern = p; overlap = ov;
    drive(v, b, 1'b1, 1'b0, tag);
  endtask

  task automatic bit_in(input logic b, input logic ez, input string tag);
    drive(1'b1, b, 1'b0, ez, tag);
  endtask

  task automatic idle(input string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst.z", {3'b0, z}, 4'h0);
    chk("rst.cnt", {2'b0, match_cnt}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    overlap = 1'b1;

    // 1011 armed from reset. Gaps in x_valid do not break the match.
    bit_in(1'b1, 1'b0, "gap.b1");
    bit_in(1'b0, 1'b0, "gap.b2");
    idle("gap.i1"); idle("gap.i2"); idle("gap.i3");
    bit_in(1'b1, 1'b0, "gap.b3");
    bit_in(1'b1, 1'b1, "gap.b4");
    idle("gap.exit");

    // Mid-stream reset discards the partial history.
    bit_in(1'b1, 1'b0, "rst2.b1");
    bit_in(1'b0, 1'b0, "rst2.b2");
    bit_in(1'b1, 1'b0, "rst2.b3");
    @(negedge clk);
    x_valid = 1'b0; rst_n = 1'b0; cnt_m = '0;
    #1;
    chk("rst2.z", {3'b0, z}, 4'h0);
    chk("rst2.cnt", {2'b0, match_cnt}, 4'h0);
    #2 rst_n = 1'b1;
    bit_in(1'b1, 1'b0, "rst2.a1");
    bit_in(1'b0, 1'b0, "rst2.a2");
    bit_in(1'b1, 1'b0, "rst2.a3");
    bit_in(1'b1, 1'b1, "rst2.a4");
    idle("rst2.exit");

    // Overlapping 1010: detections on bits 4 and 6.
    load(4'b1010, 1'b1, 1'b1, 1'b0, "ov.load");
    bit_in(1'b1, 1'b0, "ov.b1");
    bit_in(1'b0, 1'b0, "ov.b2");
    bit_in(1'b1, 1'b0, "ov.b3");
    bit_in(1'b0, 1'b1, "ov.b4");
    bit_in(1'b1, 1'b0, "ov.b5");
    bit_in(1'b0, 1'b1, "ov.b6");
    idle("ov.exit");

    // Non-overlapping 1010: detections on bits 4 and 8 only.
    load(4'b1010, 1'b0, 1'b0, 1'b0, "nov.load");
    bit_in(1'b1, 1'b0, "nov.b1");
    bit_in(1'b0, 1'b0, "nov.b2");
    bit_in(1'b1, 1'b0, "nov.b3");
    bit_in(1'b0, 1'b1, "nov.b4");
    bit_in(1'b1, 1'b0, "nov.b5");
    bit_in(1'b0, 1'b0, "nov.b6");
    bit_in(1'b1, 1'b0, "nov.b7");
    bit_in(1'b0, 1'b1, "nov.b8");
    idle("nov.exit");

    // A bit presented with pat_load is not shifted in.
    load(4'b1010, 1'b1, 1'b1, 1'b1, "ld.load");
    bit_in(1'b0, 1'b0, "ld.b1");
    bit_in(1'b1, 1'b0, "ld.b2");
    bit_in(1'b0, 1'b0, "ld.b3");
    bit_in(1'b1, 1'b0, "ld.b4");
    bit_in(1'b0, 1'b1, "ld.b5");

    // 1111 with overlap and a 2-bit counter: 5 pulses, count saturates at 3.
    load(4'b1111, 1'b1, 1'b0, 1'b0, "sat.load");
    bit_in(1'b1, 1'b0, "sat.b1");
    bit_in(1'b1, 1'b0, "sat.b2");
    bit_in(1'b1, 1'b0, "sat.b3");
    bit_in(1'b1, 1'b1, "sat.b4");
    bit_in(1'b1, 1'b1, "sat.b5");
    bit_in(1'b1, 1'b1, "sat.b6");
    bit_in(1'b1, 1'b1, "sat.b7");
    bit_in(1'b1, 1'b1, "sat.b8");
    idle("sat.exit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
